// File: rtl/map_ssf_gen_if.sv
// CPU-side bus and memory-side outputs of the SSF bank mapper.
// The master drives the CPU strobes; the mapper (slave) drives the memory controls.
interface map_ssf_gen_if #(
    parameter int MEM_AW = 23
);
    logic [23:0]       cpu_addr;
    logic [15:0]       cpu_data;
    logic              cpu_oe;
    logic              cpu_ce_lo;
    logic              cpu_we_lo;
    logic              cpu_we_hi;
    logic              cpu_tim;
    logic [MEM_AW-1:0] mem_addr;
    logic [1:0]        mem_sel;
    logic              mem_oe;
    logic              mem_we_lo;
    logic              mem_we_hi;
    logic              map_oe;

    modport master (
        output cpu_addr, cpu_data, cpu_oe, cpu_ce_lo, cpu_we_lo, cpu_we_hi, cpu_tim,
        input  mem_addr, mem_sel, mem_oe, mem_we_lo, mem_we_hi, map_oe
    );

    modport slave (
        input  cpu_addr, cpu_data, cpu_oe, cpu_ce_lo, cpu_we_lo, cpu_we_hi, cpu_tim,
        output mem_addr, mem_sel, mem_oe, mem_we_lo, mem_we_hi, map_oe
    );
endinterface

// File: rtl/map_ssf_gen.sv
// SSF-style bank-switching mapper: per-window bank remap, write protect,
// shadowed banks with atomic commit, sticky lock and full save-state access.
module map_ssf_gen #(
    parameter int         BANKS      = 8,
    parameter int         BANK_W     = 5,
    parameter int         WIN_W      = 19,
    parameter int         ROM1_FIRST = 16,
    parameter int         BRAM_FIRST = 31,
    parameter logic [3:0] REG_NIB    = 4'hF,
    parameter logic [3:0] EXT_NIB    = 4'hE
) (
    input  logic       clk,
    input  logic       map_rst,
    map_ssf_gen_if.slave bus,
    input  logic       sst_act,
    input  logic       sst_we_map,
    input  logic [7:0] sst_addr,
    input  logic [7:0] sst_dato,
    output logic [7:0] sst_di,
    output logic       cart,
    output logic       led_r
);
    localparam int WB = $clog2(BANKS);

    logic [BANK_W-1:0] bank   [BANKS];
    logic [BANK_W-1:0] shadow [BANKS];
    logic [3:0]        ctrl;
    logic [BANKS-1:0]  wp;
    logic              defer;
    logic              lock;

    logic s1, s2, s3, sync_valid, armed, reg_we;

    logic [WB-1:0]           win;
    logic [BANK_W-1:0]       cur;
    logic [BANK_W+WIN_W-1:0] phys;
    logic                    rce;
    logic                    wr_ok;
    logic                    strobe;
    logic [3:0]              nib;
    logic [3:0]              off;
    logic [WB-1:0]           reg_k;
    logic                    k_ok;
    logic [WB-1:0]           sst_k;
    logic [15:0]             wp16;
    logic                    unused_bits;

    always_comb begin
        win   = bus.cpu_addr[WIN_W+WB-1:WIN_W];
        cur   = bank[win];
        phys  = {cur, bus.cpu_addr[WIN_W-1:0]};
        rce   = !bus.cpu_ce_lo;
        wr_ok = rce & ctrl[2] & !wp[win];
        nib   = bus.cpu_addr[7:4];
        off   = bus.cpu_addr[3:0];
        reg_k = WB'(off[3:1]);
        k_ok  = !off[0] && (int'(off[3:1]) < BANKS);
        sst_k = sst_addr[WB-1:0];
        wp16  = 16'(wp);
        strobe = !bus.cpu_tim && !bus.cpu_we_lo && (nib == REG_NIB || nib == EXT_NIB);

        bus.mem_addr  = phys[BANK_W+WIN_W-2:0];
        bus.mem_oe    = rce & !bus.cpu_oe;
        bus.map_oe    = rce & !bus.cpu_oe;
        bus.mem_we_lo = wr_ok & !bus.cpu_we_lo;
        bus.mem_we_hi = wr_ok & !bus.cpu_we_hi;
        if (int'(cur) < ROM1_FIRST)
            bus.mem_sel = 2'd0;
        else if (int'(cur) < BRAM_FIRST)
            bus.mem_sel = 2'd1;
        else
            bus.mem_sel = 2'd2;
    end

    assign unused_bits = ^{bus.cpu_data, bus.cpu_addr, phys[BANK_W+WIN_W-1]};
    assign cart  = ctrl[0];
    assign led_r = ctrl[1];

    always_comb begin
        sst_di = 8'hFF;
        if (int'(sst_addr) < BANKS)
            sst_di = 8'(bank[sst_k]);
        else if (sst_addr >= 8'd32 && int'(sst_addr) < 32 + BANKS)
            sst_di = 8'(shadow[sst_k]);
        else begin
            case (sst_addr)
                8'd16:   sst_di = {4'd0, ctrl};
                8'd17:   sst_di = wp16[7:0];
                8'd18:   sst_di = wp16[15:8];
                8'd19:   sst_di = {6'd0, lock, defer};
                default: sst_di = 8'hFF;
            endcase
        end
    end

    // armed stays low while a strobe held through reset is still asserted,
    // so only a fresh assertion after reset can produce a pulse.
    always_ff @(posedge clk) begin
        if (map_rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            sync_valid <= 1'b0;
            armed      <= 1'b0;
            reg_we     <= 1'b0;
        end else begin
            s1         <= strobe;
            s2         <= s1;
            s3         <= s2;
            sync_valid <= 1'b1;
            armed      <= armed | (sync_valid & !s1);
            reg_we     <= s2 & !s3 & armed;
        end
    end

    always_ff @(posedge clk) begin
        if (map_rst) begin
            for (int unsigned i = 0; i < BANKS; i++) begin
                bank[i]   <= BANK_W'(i);
                shadow[i] <= BANK_W'(i);
            end
            ctrl  <= '0;
            wp    <= '0;
            defer <= 1'b0;
            lock  <= 1'b0;
        end else if (sst_we_map) begin
            if (int'(sst_addr) < BANKS)
                bank[sst_k] <= sst_dato[BANK_W-1:0];
            else if (sst_addr >= 8'd32 && int'(sst_addr) < 32 + BANKS)
                shadow[sst_k] <= sst_dato[BANK_W-1:0];
            else begin
                case (sst_addr)
                    8'd16: ctrl <= sst_dato[3:0];
                    8'd17: wp   <= BANKS'({wp16[15:8], sst_dato});
                    8'd18: wp   <= BANKS'({sst_dato, wp16[7:0]});
                    8'd19: begin
                        defer <= sst_dato[0];
                        lock  <= sst_dato[1];
                    end
                    default: ;
                endcase
            end
        end else if (reg_we && !sst_act && !lock) begin
            if (nib == REG_NIB) begin
                if (k_ok && (off[3:1] != 3'd0 || bus.cpu_data[15])) begin
                    if (off[3:1] == 3'd0)
                        ctrl <= bus.cpu_data[14:11];
                    shadow[reg_k] <= bus.cpu_data[BANK_W-1:0];
                    if (!defer)
                        bank[reg_k] <= bus.cpu_data[BANK_W-1:0];
                end
            end else if (nib == EXT_NIB) begin
                case (off)
                    4'd0: wp <= bus.cpu_data[BANKS-1:0];
                    4'd2: begin
                        if (bus.cpu_data[0])
                            for (int unsigned i = 0; i < BANKS; i++)
                                bank[i] <= shadow[i];
                    end
                    4'd4: begin
                        defer <= bus.cpu_data[0];
                        lock  <= lock | bus.cpu_data[1];
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_map_ssf_gen.sv
// Directed self-checking bench for map_ssf_gen (BANKS=8, BANK_W=5, WIN_W=19).
module tb_map_ssf_gen;
    logic       clk = 1'b0;
    logic       map_rst;
    logic       sst_act, sst_we_map;
    logic [7:0] sst_addr, sst_dato, sst_di;
    logic       cart, led_r;

    int checks = 0;
    int errors = 0;

    map_ssf_gen_if #(.MEM_AW(23)) bus ();

    map_ssf_gen #(
        .BANKS(8), .BANK_W(5), .WIN_W(19), .ROM1_FIRST(16), .BRAM_FIRST(31),
        .REG_NIB(4'hF), .EXT_NIB(4'hE)
    ) dut (
        .clk(clk), .map_rst(map_rst), .bus(bus),
        .sst_act(sst_act), .sst_we_map(sst_we_map), .sst_addr(sst_addr),
        .sst_dato(sst_dato), .sst_di(sst_di), .cart(cart), .led_r(led_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        logic        ce_lo, oe, we_lo, we_hi;
        logic [22:0] e_addr;
        logic [1:0]  e_sel;
        logic        e_oe, e_we_lo, e_we_hi;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sst_rd(input logic [7:0] idx, input logic [7:0] exp, input string name);
        sst_addr = idx;
        #1;
        check(name, 32'(sst_di), 32'(exp));
    endtask

    task automatic sst_wr(input logic [7:0] idx, input logic [7:0] val);
        sst_act = 1'b1; sst_we_map = 1'b1; sst_addr = idx; sst_dato = val;
        tick();
        sst_act = 1'b0; sst_we_map = 1'b0;
    endtask

    task automatic strobe_on(input logic [23:0] a, input logic [15:0] d);
        bus.cpu_addr = a; bus.cpu_data = d;
        bus.cpu_tim = 1'b0; bus.cpu_we_lo = 1'b0;
    endtask

    task automatic strobe_off();
        bus.cpu_tim = 1'b1; bus.cpu_we_lo = 1'b1;
    endtask

    task automatic reg_write(input logic [23:0] a, input logic [15:0] d);
        strobe_on(a, d);
        repeat (4) tick();
        strobe_off();
        repeat (3) tick();
    endtask

    task automatic rd(input logic [23:0] a, input logic [1:0] sel, input logic [22:0] maddr, input string name);
        bus.cpu_addr = a; bus.cpu_ce_lo = 1'b0; bus.cpu_oe = 1'b0;
        #1;
        check({name, "_sel"}, 32'(bus.mem_sel), 32'(sel));
        check({name, "_addr"}, 32'(bus.mem_addr), 32'(maddr));
        check({name, "_oe"}, 32'({bus.mem_oe, bus.map_oe}), 32'(2'b11));
        bus.cpu_ce_lo = 1'b1; bus.cpu_oe = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // state at table time: bank = {31,1,2,20,4,16,30,15}, wp=0x04, ctrl=5
        vecs[0] = '{24'h000010, 1'b0, 1'b0, 1'b1, 1'b1, 23'h780010, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{24'h180004, 1'b0, 1'b0, 1'b1, 1'b1, 23'h200004, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{24'h100000, 1'b0, 1'b1, 1'b0, 1'b0, 23'h100000, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{24'h080002, 1'b0, 1'b1, 1'b0, 1'b0, 23'h080002, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{24'h2ABCDE, 1'b0, 1'b1, 1'b0, 1'b1, 23'h02BCDE, 2'd1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{24'h3FFFFE, 1'b1, 1'b0, 1'b0, 1'b0, 23'h7FFFFE, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{24'h7FFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 23'h7FFFFF, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{24'h1FFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 23'h27FFFE, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{24'h300000, 1'b0, 1'b0, 1'b1, 1'b1, 23'h700000, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{24'h200000, 1'b0, 1'b0, 1'b1, 1'b1, 23'h200000, 2'd0, 1'b1, 1'b0, 1'b0};

        bus.cpu_addr = '0; bus.cpu_data = '0; bus.cpu_oe = 1'b1; bus.cpu_ce_lo = 1'b1;
        bus.cpu_we_lo = 1'b1; bus.cpu_we_hi = 1'b1; bus.cpu_tim = 1'b1;
        sst_act = 1'b0; sst_we_map = 1'b0; sst_addr = '0; sst_dato = '0;
        map_rst = 1'b1;
        repeat (3) tick();
        map_rst = 1'b0;
        repeat (3) tick();

        // reset state
        rd(24'h080000, 2'd0, 23'h080000, "rst_rd");
        check("rst_cart", 32'({cart, led_r}), 32'(2'b00));
        sst_rd(8'd17, 8'h00, "rst_wp");
        sst_rd(8'd19, 8'h00, "rst_lockdefer");
        sst_rd(8'd5, 8'd5, "rst_bank5");
        sst_rd(8'd37, 8'd5, "rst_shadow5");

        // ctrl + bank0 write, then data[15]=0 is ignored
        reg_write(24'h0000F0, 16'h881F);
        check("ctrl_cart", 32'({cart, led_r}), 32'(2'b10));
        sst_rd(8'd0, 8'd31, "bank0_31");
        rd(24'h000010, 2'd2, 23'h780010, "bram_rd");
        reg_write(24'h0000F0, 16'h0005);
        sst_rd(8'd0, 8'd31, "noop_bank0");
        sst_rd(8'd16, 8'd1, "noop_ctrl");

        // deferred bank write and commit timing
        reg_write(24'h0000E4, 16'h0001);
        sst_rd(8'd19, 8'h01, "defer_set");
        reg_write(24'h0000F6, 16'd20);
        rd(24'h180000, 2'd0, 23'h180000, "defer_old");
        sst_rd(8'd35, 8'd20, "defer_shadow3");
        strobe_on(24'h0000E2, 16'h0001);
        repeat (3) tick();
        sst_rd(8'd3, 8'd3, "commit_n2");
        tick();
        sst_rd(8'd3, 8'd20, "commit_n3");
        strobe_off();
        repeat (3) tick();
        rd(24'h180000, 2'd1, 23'h200000, "commit_rd");

        // write-enable setup and translation table
        reg_write(24'h0000E4, 16'h0000);
        reg_write(24'h0000F0, 16'hA81F);
        check("ctrl5_cart", 32'({cart, led_r}), 32'(2'b10));
        sst_rd(8'd16, 8'd5, "ctrl5");
        reg_write(24'h0000E0, 16'h0004);
        sst_rd(8'd17, 8'h04, "wp_04");
        sst_wr(8'd5, 8'd16);
        sst_wr(8'd6, 8'd30);
        sst_wr(8'd7, 8'd15);
        for (int i = 0; i < 10; i++) begin
            bus.cpu_addr = vecs[i].addr; bus.cpu_ce_lo = vecs[i].ce_lo; bus.cpu_oe = vecs[i].oe;
            bus.cpu_we_lo = vecs[i].we_lo; bus.cpu_we_hi = vecs[i].we_hi;
            #1;
            check($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_sel", i), 32'(bus.mem_sel), 32'(vecs[i].e_sel));
            check($sformatf("vec%0d_en", i), 32'({bus.mem_oe, bus.map_oe, bus.mem_we_lo, bus.mem_we_hi}),
                  32'({vecs[i].e_oe, vecs[i].e_oe, vecs[i].e_we_lo, vecs[i].e_we_hi}));
        end
        bus.cpu_ce_lo = 1'b1; bus.cpu_oe = 1'b1; bus.cpu_we_lo = 1'b1; bus.cpu_we_hi = 1'b1;
        tick();

        // lock, save-state unlock, unmapped index
        reg_write(24'h0000E4, 16'h0002);
        sst_rd(8'd19, 8'h02, "lock_set");
        reg_write(24'h0000F2, 16'd9);
        sst_rd(8'd1, 8'd1, "locked_bank1");
        sst_wr(8'd19, 8'h00);
        sst_rd(8'd19, 8'h00, "lock_clr");
        reg_write(24'h0000F2, 16'd9);
        sst_rd(8'd1, 8'd9, "unlocked_bank1");
        sst_rd(8'd33, 8'd9, "unlocked_shadow1");
        sst_rd(8'd40, 8'hFF, "unmapped40");
        sst_rd(8'd12, 8'hFF, "unmapped12");

        // held strobe: sst_act in the pulse cycle drops it, and no re-pulse
        strobe_on(24'h0000F4, 16'd7);
        repeat (3) tick();
        sst_act = 1'b1;
        tick();
        sst_act = 1'b0;
        repeat (16) tick();
        strobe_off();
        repeat (3) tick();
        sst_rd(8'd2, 8'd2, "sstact_drop");
        strobe_on(24'h0000F4, 16'd7);
        repeat (4) tick();
        bus.cpu_data = 16'd6;
        repeat (16) tick();
        strobe_off();
        repeat (3) tick();
        sst_rd(8'd2, 8'd7, "held_one_pulse");
        sst_rd(8'd34, 8'd7, "held_shadow2");

        // strobe held across reset produces no pulse until re-asserted
        strobe_on(24'h0000F8, 16'd11);
        map_rst = 1'b1;
        repeat (3) tick();
        map_rst = 1'b0;
        repeat (10) tick();
        sst_rd(8'd4, 8'd4, "rst_held_bank4");
        sst_rd(8'd0, 8'd0, "rst2_bank0");
        sst_rd(8'd17, 8'h00, "rst2_wp");
        check("rst2_cart", 32'({cart, led_r}), 32'(2'b00));
        strobe_off();
        repeat (3) tick();
        reg_write(24'h0000F8, 16'd11);
        sst_rd(8'd4, 8'd11, "rearm_bank4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
